// File: rtl/afifo_out_if.sv
// rtl/afifo_out_if.sv - block-in / word-out handshake bundle for afifo_out; error ports only with AFIFO_OUT_ERR_EN
interface afifo_out_if #(
    parameter int DEPTH = 2
);
    localparam int AW = $clog2(4 * DEPTH + 1);

    logic          write_en;
    logic [127:0]  data_in;
    logic          read_en;
    logic [31:0]   data_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW-1:0] words_avail;
`ifdef AFIFO_OUT_ERR_EN
    logic          overflow;
    logic          underflow;
    logic          err_clr;
`endif

    modport master (
        output write_en, data_in, read_en,
        input  data_out, fifo_empty, fifo_full, words_avail
`ifdef AFIFO_OUT_ERR_EN
        , output err_clr
        , input  overflow, underflow
`endif
    );

    modport slave (
        input  write_en, data_in, read_en,
        output data_out, fifo_empty, fifo_full, words_avail
`ifdef AFIFO_OUT_ERR_EN
        , input  err_clr
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/afifo_out.sv
// rtl/afifo_out.sv - 128-bit block in, 32-bit word out FIFO (MSW first, show-ahead); AFIFO_OUT_ERR_EN adds sticky error flags
module afifo_out #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    afifo_out_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(4 * DEPTH + 1);

    logic [127:0]  slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    word_idx;
    logic [CW-1:0] blk_cnt;

    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;
    logic          blk_free;
    logic [127:0]  head;
    logic [31:0]   head_word;

    assign full  = (blk_cnt == CW'(DEPTH));
    assign empty = (blk_cnt == '0);

    // Both accept decisions use the pre-edge flags, so a full FIFO drops a write
    // even when the same edge frees a slot.
    assign wr_ok    = bus.write_en && !full;
    assign rd_ok    = bus.read_en && !empty;
    assign blk_free = rd_ok && (word_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            blk_cnt  <= '0;
        end else begin
            if (wr_ok) begin
                slots[wr_ptr] <= bus.data_in;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                word_idx <= word_idx + 2'd1;
                if (word_idx == 2'd3) rd_ptr <= rd_ptr + 1'b1;
            end
            blk_cnt <= blk_cnt + CW'(wr_ok) - CW'(blk_free);
        end
    end

    always_comb begin
        head      = slots[rd_ptr];
        head_word = '0;
        case (word_idx)
            2'd0: head_word = head[127:96];
            2'd1: head_word = head[95:64];
            2'd2: head_word = head[63:32];
            2'd3: head_word = head[31:0];
            default: head_word = '0;
        endcase
    end

    assign bus.data_out    = empty ? 32'h0 : head_word;
    assign bus.fifo_empty  = empty;
    assign bus.fifo_full   = full;
    assign bus.words_avail = AW'({blk_cnt, 2'b00}) - AW'(word_idx);

`ifdef AFIFO_OUT_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Clear has priority over a set arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.err_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.write_en && full) overflow_q  <= 1'b1;
            if (bus.read_en && empty) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_afifo_out.sv
// tb/tb_afifo_out.sv - self-checking bench for afifo_out against a word-queue reference model
module tb_afifo_out;
    localparam int DEPTH = 2;
    localparam int AW = $clog2(4 * DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    afifo_out_if #(.DEPTH(DEPTH)) bus ();
    afifo_out #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;

    // Reference: the FIFO is just an ordered list of pending words; a block
    // occupies a slot until its last word leaves.
    logic [31:0] mq[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    function automatic int m_blocks();
        return (mq.size() + 3) / 4;
    endfunction

    function automatic logic [31:0] m_head();
        return (mq.size() > 0) ? mq[0] : 32'h0;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return b[127 - 32 * i -: 32];
    endfunction

    task automatic cycle(input bit r, input bit we, input logic [127:0] d, input bit re, input bit clr);
        bit full_m;
        bit empty_m;
        rst          = r;
        bus.write_en = we;
        bus.data_in  = d;
        bus.read_en  = re;
`ifdef AFIFO_OUT_ERR_EN
        bus.err_clr  = clr;
`endif
        full_m  = (m_blocks() == DEPTH);
        empty_m = (mq.size() == 0);
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (re && !empty_m) void'(mq.pop_front());
            if (we && !full_m) for (int i = 0; i < 4; i++) mq.push_back(word_of(d, i));
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (we && full_m) m_ovf = 1'b1;
                if (re && empty_m) m_unf = 1'b1;
            end
        end
        rst          = 1'b0;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
`ifdef AFIFO_OUT_ERR_EN
        bus.err_clr  = 1'b0;
`endif
    endtask

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        cycle(1, 1, rnd_blk(), 1, 1);
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.fifo_empty); end
        total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.fifo_full); end
        total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.data_out); end
        total++; if (bus.words_avail !== AW'(0)) begin bad++; $display("FAIL reset_words got=%0d want=0", bus.words_avail); end
`ifdef AFIFO_OUT_ERR_EN
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", bus.overflow, bus.underflow); end
`endif
    endtask

    task automatic test_single();
        logic [127:0] blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        logic [31:0] exp_w [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        cycle(0, 1, blk, 0, 0);
        total++; if (bus.words_avail !== AW'(4)) begin bad++; $display("FAIL single_words got=%0d want=4", bus.words_avail); end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.data_out !== exp_w[i]) begin bad++; $display("FAIL single_word%0d got=%h want=%h", i, bus.data_out, exp_w[i]); end
            cycle(0, 0, '0, 1, 0);
        end
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", bus.fifo_empty); end
    endtask

    task automatic test_fill();
        logic [127:0] a = rnd_blk();
        logic [127:0] b = rnd_blk();
        logic [31:0] exp;
        cycle(0, 1, a, 0, 0);
        cycle(0, 1, b, 0, 0);
        total++; if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", bus.fifo_full); end
        total++; if (bus.words_avail !== AW'(8)) begin bad++; $display("FAIL fill_words got=%0d want=8", bus.words_avail); end
        cycle(0, 1, rnd_blk(), 0, 0);
        total++; if (bus.words_avail !== AW'(8)) begin bad++; $display("FAIL fill_drop_words got=%0d want=8", bus.words_avail); end
`ifdef AFIFO_OUT_ERR_EN
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b want=1", bus.overflow); end
        cycle(0, 0, '0, 0, 1);
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_clr got=%b want=0", bus.overflow); end
`endif
        for (int i = 0; i < 8; i++) begin
            exp = (i < 4) ? word_of(a, i) : word_of(b, i - 4);
            total++; if (bus.data_out !== exp) begin bad++; $display("FAIL fill_word%0d got=%h want=%h", i, bus.data_out, exp); end
            cycle(0, 0, '0, 1, 0);
        end
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL fill_empty got=%b want=1", bus.fifo_empty); end
    endtask

    task automatic test_concurrent();
        logic [127:0] a = rnd_blk();
        logic [127:0] b = rnd_blk();
        logic [127:0] c = rnd_blk();
        logic [31:0] exp;
        cycle(0, 1, a, 0, 0);
        cycle(0, 1, b, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 0);
        cycle(0, 1, c, 1, 0);
        total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL conc_full got=%b want=0", bus.fifo_full); end
        total++; if (bus.words_avail !== AW'(4)) begin bad++; $display("FAIL conc_words got=%0d want=4", bus.words_avail); end
        cycle(0, 1, c, 0, 0);
        total++; if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL conc_refill got=%b want=1", bus.fifo_full); end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 4) ? word_of(b, i) : word_of(c, i - 4);
            total++; if (bus.data_out !== exp) begin bad++; $display("FAIL conc_word%0d got=%h want=%h", i, bus.data_out, exp); end
            cycle(0, 0, '0, 1, 0);
        end
    endtask

    task automatic test_stream();
        logic [127:0] blks [6];
        logic [31:0] exp [$];
        int wr_i = 0;
        int got = 0;
        bit we;
        bit re;
        for (int i = 0; i < 6; i++) begin
            blks[i] = rnd_blk();
            for (int k = 0; k < 4; k++) exp.push_back(word_of(blks[i], k));
        end
        for (int cyc = 0; cyc < 300 && got < 24; cyc++) begin
            we = (wr_i < 6) && (m_blocks() < DEPTH);
            re = ($urandom_range(0, 3) != 0);
            if (re && mq.size() > 0) begin
                total++; if (bus.data_out !== exp[got]) begin bad++; $display("FAIL stream_word%0d got=%h want=%h", got, bus.data_out, exp[got]); end
                got++;
            end
            cycle(0, we, we ? blks[wr_i] : 128'h0, re, 0);
            if (we) wr_i++;
        end
        total++; if (got != 24) begin bad++; $display("FAIL stream_count got=%0d want=24", got); end
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL stream_empty got=%b want=1", bus.fifo_empty); end
    endtask

    task automatic test_mid_drain_reset();
        logic [127:0] d = rnd_blk();
        cycle(0, 1, rnd_blk(), 0, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(1, 0, rnd_blk(), 0, 0);
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL mdr_empty got=%b want=1", bus.fifo_empty); end
        total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL mdr_data got=%h want=0", bus.data_out); end
        cycle(0, 1, d, 0, 0);
        total++; if (bus.data_out !== d[127:96]) begin bad++; $display("FAIL mdr_d0 got=%h want=%h", bus.data_out, d[127:96]); end
        total++; if (bus.words_avail !== AW'(4)) begin bad++; $display("FAIL mdr_words got=%0d want=4", bus.words_avail); end
        cycle(1, 0, '0, 0, 0);
    endtask

    task automatic test_underflow();
        cycle(0, 1, rnd_blk(), 1, 0);
        total++; if (bus.words_avail !== AW'(4)) begin bad++; $display("FAIL uf_empty_wr got=%0d want=4", bus.words_avail); end
`ifdef AFIFO_OUT_ERR_EN
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b want=1", bus.underflow); end
`endif
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 1, 1);
`ifdef AFIFO_OUT_ERR_EN
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL uf_clr_wins got=%b want=0", bus.underflow); end
`endif
        total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL uf_data got=%h want=0", bus.data_out); end
    endtask

    task automatic test_random();
        bit we;
        bit re;
        bit clr;
        for (int cyc = 0; cyc < 400; cyc++) begin
            we  = ($urandom_range(0, 1) != 0);
            re  = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 19) == 0);
            cycle(0, we, rnd_blk(), re, clr);
            total++; if (bus.data_out !== m_head()) begin bad++; $display("FAIL rnd_data c%0d got=%h want=%h", cyc, bus.data_out, m_head()); end
            total++; if (bus.words_avail !== AW'(mq.size())) begin bad++; $display("FAIL rnd_words c%0d got=%0d want=%0d", cyc, bus.words_avail, mq.size()); end
            total++; if (bus.fifo_full !== (m_blocks() == DEPTH)) begin bad++; $display("FAIL rnd_full c%0d got=%b", cyc, bus.fifo_full); end
            total++; if (bus.fifo_empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty c%0d got=%b", cyc, bus.fifo_empty); end
`ifdef AFIFO_OUT_ERR_EN
            total++; if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin bad++; $display("FAIL rnd_err c%0d got=%b%b want=%b%b", cyc, bus.overflow, bus.underflow, m_ovf, m_unf); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_concurrent();
        test_stream();
        test_mid_drain_reset();
        test_underflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
